serial_compare_sequencer: RTL
=============================

Name: serial_compare_sequencer

Overview:
- Controller that drives a bit-serial magnitude comparator from parallel operands.
- Accepts two WIDTH-bit words through a valid/ready handshake.
- Shifts the words out one bit per cycle, either MSB-first or LSB-first as selected per transaction, into internal serial compare state.
- Presents a registered less/equal/greater result and bit count through a second valid/ready handshake.
- Sits between a parallel requester and the serial comparison datapath.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 2 or more.
- EARLY_EXIT, 1, when 1 an MSB-first transaction ends as soon as the result is decided.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_msb_first  in  1  1 = MSB-first order, 0 = LSB-first order; latched at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- a_less_b  out  1  result: A < B (unsigned).
- a_eq_b  out  1  result: A == B.
- a_greater_b  out  1  result: A > B.
- bits_used  out  $clog2(WIDTH+1)  number of bit cycles consumed by the transaction.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - a_less_b = a_eq_b = a_greater_b = 0; bits_used = 0.
  - Shift registers cleared; any in-flight transaction is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge E0: latch in_a, in_b and in_msb_first.
  - Initialise internal compare state to eq = 1, less = 0, and the bit counter to 0.
  - Go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - On edge Ej (j = 1..WIDTH), process one bit pair:
    - MSB-first mode processes index WIDTH-j.
    - LSB-first mode processes index j-1.
  - Counter becomes j.
  - MSB-first update: less' = less | (eq & ~a & b); eq' = eq & (a == b).
  - LSB-first update: less' = (~a & b) | ((a == b) & less); eq' = eq & (a == b).
  - greater = ~eq & ~less, derived at result capture.
  - Transaction terminates at edge Ej when j == WIDTH, or when EARLY_EXIT = 1, MSB-first is selected and eq' == 0.
  - On termination:
    - Result flags and bits_used = j are registered.
    - out_valid = 1.
    - Go to DONE.
  - Latency from accept edge to out_valid high: WIDTH cycles. In the MSB-first early-exit case it is k+1 cycles, where k is the position of the first differing bit counted from the MSB (k = 0 for the MSB itself).
  - LSB-first never exits early.
- DONE:
  - out_valid = 1; result and bits_used held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_valid & out_ready: out_valid = 0, result outputs = 0, go to IDLE. in_ready is 1 in the following cycle.
  - No bypass from DONE to SHIFT; minimum spacing between accepts is latency + 2 cycles.
- Exactly one of the three result flags is high whenever out_valid = 1. All three are 0 whenever out_valid = 0.
- Operands are unsigned.
- Input changes after accept have no effect.
- in_valid may fall without acceptance; the block does not require it to be held.

Test Plan:
- Reset, then in_a = 8'h5A, in_b = 8'h5A, MSB-first, out_ready = 1 -> out_valid exactly 8 cycles after accept; a_eq_b = 1; bits_used = 8; in_ready returns to 1 one cycle after the result handshake.
- in_a = 8'h80, in_b = 8'h7F, MSB-first, EARLY_EXIT = 1 -> out_valid 1 cycle after accept; a_greater_b = 1; bits_used = 1.
- in_a = 8'h12, in_b = 8'h13, MSB-first -> differing bit at index 0 (k = 7); out_valid 8 cycles after accept; a_less_b = 1; bits_used = 8.
- in_a = 8'h01, in_b = 8'h80, LSB-first -> no early exit; out_valid 8 cycles after accept; a_less_b = 1; bits_used = 8.
- out_ready held 0 for 5 cycles in DONE while in_valid = 1 with new operands -> result stable; in_ready = 0; no new accept; result drops on out_ready, then the new request is accepted.
- Assert rst for 1 cycle at the 4th SHIFT cycle -> outputs go to reset values immediately with no clock edge needed; in_ready = 1 after release; the next transaction (in_a = 8'h03, in_b = 8'h02, MSB-first) gives a_greater_b = 1, bits_used = 8.

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// Sequencer feeding parallel operands bit-serially into an unsigned magnitude compare.
// Supports MSB-first (with optional early exit) and LSB-first ordering per transaction.
module serial_compare_sequencer #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_msb_first,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       a_less_b,
    output logic                       a_eq_b,
    output logic                       a_greater_b,
    output logic [$clog2(WIDTH+1)-1:0] bits_used
);

    localparam int CW = $clog2(WIDTH+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             msb_mode;
    logic             eq;
    logic             less;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             eq_n;
    logic             less_n;
    logic [CW-1:0]    cnt_n;
    logic             last;

    // The active bit always sits at one end of the shift register, so no index mux is needed.
    always_comb begin
        bit_a  = msb_mode ? a_sh[WIDTH-1] : a_sh[0];
        bit_b  = msb_mode ? b_sh[WIDTH-1] : b_sh[0];
        eq_n   = eq & (bit_a == bit_b);
        if (msb_mode)
            less_n = less | (eq & ~bit_a & bit_b);
        else
            less_n = (~bit_a & bit_b) | ((bit_a == bit_b) & less);
        cnt_n  = cnt + CW'(1);
        last   = (cnt_n == CW'(WIDTH)) || (EARLY_EXIT && msb_mode && !eq_n);
    end

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            msb_mode    <= 1'b0;
            eq          <= 1'b1;
            less        <= 1'b0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            a_less_b    <= 1'b0;
            a_eq_b      <= 1'b0;
            a_greater_b <= 1'b0;
            bits_used   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= in_a;
                        b_sh     <= in_b;
                        msb_mode <= in_msb_first;
                        eq       <= 1'b1;
                        less     <= 1'b0;
                        cnt      <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (msb_mode) begin
                        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                    end else begin
                        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    end
                    eq   <= eq_n;
                    less <= less_n;
                    cnt  <= cnt_n;
                    if (last) begin
                        a_less_b    <= less_n;
                        a_eq_b      <= eq_n;
                        a_greater_b <= ~eq_n & ~less_n;
                        bits_used   <= cnt_n;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        a_less_b    <= 1'b0;
                        a_eq_b      <= 1'b0;
                        a_greater_b <= 1'b0;
                        bits_used   <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
